// File: rtl/vga_sprite_compositor.sv
// Sprite-over-tilemap pixel compositor with double-buffered sprite registers and a two-strobe pipeline.
// Optional per-sprite collision flags are built when SPRITE_COLLISION_EN is defined.

module vga_sprite_lane #(
  parameter int SPR_W = 23,
  parameter int SPR_H = 31
) (
  input  logic       en_i,
  input  logic       mirror_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       hit_o,
  output logic [9:0] addr_o
);
  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy, dx_m;

  // 11-bit ends so sprites near the right/bottom edge never wrap
  assign x_end = {1'b0, x_i} + 11'(SPR_W);
  assign y_end = {1'b0, y_i} + 11'(SPR_H);
  assign hit_o = en_i && (draw_x_i >= x_i) && ({1'b0, draw_x_i} < x_end)
                      && (draw_y_i >= y_i) && ({1'b0, draw_y_i} < y_end);
  assign dx    = draw_x_i - x_i;
  assign dy    = draw_y_i - y_i;
  assign dx_m  = mirror_i ? 10'(SPR_W - 1) - dx : dx;
  assign addr_o = hit_o ? 10'(int'(dy) * SPR_W + int'(dx_m)) : '0;
endmodule

module vga_sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_W       = 23,
  parameter int          SPR_H       = 31,
  parameter int          TILE_W      = 16,
  parameter int          MAP_COLS    = 40,
  parameter int          MAP_ROWS    = 30,
  parameter int          COLOR_W     = 4,
  parameter logic [23:0] TRANSP_KEY  = 24'hFF00FF,
  localparam int SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int MAP_AW = $clog2(MAP_COLS * MAP_ROWS),
  localparam int PIX_AW = $clog2(TILE_W * TILE_W)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     pix_en,
  input  logic                     frame_start,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  input  logic                     blank,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     cfg_we,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic [23:0]              cfg_wdata,
  output logic [MAP_AW-1:0]        map_addr,
  input  logic                     map_bit,
  output logic [PIX_AW-1:0]        pix_addr,
  input  logic [23:0]              bg_data,
  input  logic [23:0]              tile_data,
  output logic [NUM_SPRITES*10-1:0] spr_addr,
  input  logic [NUM_SPRITES*24-1:0] spr_data,
  output logic [COLOR_W-1:0]       red,
  output logic [COLOR_W-1:0]       green,
  output logic [COLOR_W-1:0]       blue,
  output logic                     hs,
  output logic                     vs,
  output logic [NUM_SPRITES-1:0]   coll_flags
);
  localparam int TB = $clog2(TILE_W);

  // Register layout: {en, mirror, y[9:0], x[9:0]}; cfg_wdata[21:20] is padding
  logic [NUM_SPRITES-1:0][21:0] pend_q, act_q;
  logic                         unused_pad;
  assign unused_pad = ^cfg_wdata[21:20];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      if (frame_start) act_q <= pend_q;
      if (cfg_we && (32'(cfg_sel) < NUM_SPRITES))
        pend_q[cfg_sel] <= {cfg_wdata[23:22], cfg_wdata[19:0]};
    end
  end

  logic [NUM_SPRITES-1:0]       hit_d;
  logic [NUM_SPRITES-1:0][9:0]  saddr_d;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_lane
    vga_sprite_lane #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_lane (
      .en_i     (act_q[g][21]),
      .mirror_i (act_q[g][20]),
      .y_i      (act_q[g][19:10]),
      .x_i      (act_q[g][9:0]),
      .draw_x_i (draw_x),
      .draw_y_i (draw_y),
      .hit_o    (hit_d[g]),
      .addr_o   (saddr_d[g])
    );
  end

  logic [MAP_AW-1:0] map_d;
  logic [PIX_AW-1:0] pix_d;
  assign map_d = MAP_AW'(int'(draw_y >> TB) * MAP_COLS + int'(draw_x >> TB));
  assign pix_d = {draw_y[TB-1:0], draw_x[TB-1:0]};

  // Stage A: addresses and side-band captured on the pixel strobe
  logic [MAP_AW-1:0]            map_q;
  logic [PIX_AW-1:0]            pix_q;
  logic [NUM_SPRITES-1:0][9:0]  saddr_q;
  logic [NUM_SPRITES-1:0]       hit_q;
  logic                         blank_q, hs_a_q, vs_a_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      map_q   <= '0;
      pix_q   <= '0;
      saddr_q <= '0;
      hit_q   <= '0;
      blank_q <= 1'b0;
      hs_a_q  <= 1'b1;
      vs_a_q  <= 1'b1;
    end else if (pix_en) begin
      map_q   <= map_d;
      pix_q   <= pix_d;
      saddr_q <= saddr_d;
      hit_q   <= hit_d;
      blank_q <= blank;
      hs_a_q  <= hs_in;
      vs_a_q  <= vs_in;
    end
  end

  assign map_addr = map_q;
  assign pix_addr = pix_q;
  assign spr_addr = saddr_q;

  // Stage B: compose from the memory data returned for the stage-A addresses
  logic [NUM_SPRITES-1:0][23:0] sdat;
  logic [NUM_SPRITES-1:0]       opaque;
  logic [23:0]                  rgb;
  assign sdat = spr_data;

  always_comb begin
    rgb = map_bit ? tile_data : bg_data;
    for (int i = 0; i < NUM_SPRITES; i++)
      opaque[i] = hit_q[i] && (sdat[i] != TRANSP_KEY);
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (opaque[i]) rgb = sdat[i];
    if (!blank_q) rgb = '0;
  end

  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic               hs_q, vs_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (pix_en) begin
      red_q   <= rgb[23 -: COLOR_W];
      green_q <= rgb[15 -: COLOR_W];
      blue_q  <= rgb[7  -: COLOR_W];
      hs_q    <= hs_a_q;
      vs_q    <= vs_a_q;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hs    = hs_q;
  assign vs    = vs_q;

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] acc_q, coll_q;
  logic                   multi;
  // at least two bits set: clearing the lowest set bit leaves something
  assign multi = |(opaque & (opaque - NUM_SPRITES'(1)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else if (frame_start) begin
      coll_q <= acc_q;
      acc_q  <= '0;
    end else if (pix_en && blank_q && multi) begin
      acc_q  <= acc_q | opaque;
    end
  end

  assign coll_flags = coll_q;
`else
  assign coll_flags = '0;
`endif
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: addresses, priority, transparency, shadow swap, reset, collisions.

module tb_vga_sprite_compositor;
`ifdef SPRITE_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en, frame_start, blank, hs_in, vs_in, cfg_we, map_bit;
  logic [9:0]  draw_x, draw_y;
  logic [1:0]  cfg_sel;
  logic [23:0] cfg_wdata, bg_data, tile_data;
  logic [10:0] map_addr;
  logic [7:0]  pix_addr;
  logic [39:0] spr_addr;
  logic [95:0] spr_data;
  logic [3:0]  red, green, blue, coll_flags;
  logic        hs, vs;

  logic [23:0] spr_tex [4];
  logic        solid;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vga_sprite_compositor dut (
    .CLK(clk), .RESET(rst), .pix_en(pix_en), .frame_start(frame_start),
    .draw_x(draw_x), .draw_y(draw_y), .blank(blank), .hs_in(hs_in), .vs_in(vs_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .map_addr(map_addr), .map_bit(map_bit), .pix_addr(pix_addr),
    .bg_data(bg_data), .tile_data(tile_data), .spr_addr(spr_addr), .spr_data(spr_data),
    .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs), .coll_flags(coll_flags)
  );

  // 1-CLK latency memories
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) spr_data[i*24 +: 24] <= spr_tex[i];
    bg_data   <= 24'h112233;
    tile_data <= 24'h445566;
    map_bit   <= solid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic b, input logic h, input logic v);
    @(negedge clk);
    pix_en = 1'b1; draw_x = 10'(x); draw_y = 10'(y); blank = b; hs_in = h; vs_in = v;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic cfg(input int sel, input logic [23:0] d, input logic fs);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_wdata = d; frame_start = fs;
    @(negedge clk);
    cfg_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic fstart();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic rgb_is(input string tag, input logic [11:0] exp);
    check(tag, {red, green, blue}, exp);
  endtask

  function automatic logic [23:0] spr(input logic en, input logic mir, input int x, input int y);
    return {en, mir, 2'b00, 10'(y), 10'(x)};
  endfunction

  initial begin
    rst = 1'b1; pix_en = 0; frame_start = 0; blank = 0; hs_in = 0; vs_in = 0;
    cfg_we = 0; cfg_sel = 0; cfg_wdata = 0; draw_x = 0; draw_y = 0; solid = 0;
    for (int i = 0; i < 4; i++) spr_tex[i] = 24'h000000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rgb_is("rst_rgb", 12'h000);
    check("rst_sync", {hs, vs}, 2'b11);
    check("rst_coll", coll_flags, 4'h0);
    check("rst_addr", {map_addr, pix_addr, spr_addr}, 59'h0);

    // single sprite, swapped in at frame start
    spr_tex[0] = 24'hA0B0C0;
    cfg(0, spr(1, 0, 100, 50), 1'b0);
    pix(100, 50, 1, 1, 1);
    check("pending_no_hit", spr_addr[9:0], 10'd0);
    fstart();
    pix(100, 50, 1, 0, 1);
    check("map_addr", map_addr, 11'd126);
    check("pix_addr", pix_addr, 8'd36);
    pix(122, 80, 1, 1, 0);
    check("sa_corner", spr_addr[9:0], 10'd712);
    rgb_is("rgb_100_50", 12'hABC);
    check("sync_100_50", {hs, vs}, 2'b01);
    pix(123, 50, 1, 1, 1);
    check("sa_outside", spr_addr[9:0], 10'd0);
    rgb_is("rgb_122_80", 12'hABC);
    check("sync_122_80", {hs, vs}, 2'b10);
    pix(100, 50, 0, 1, 1);
    rgb_is("rgb_123_50_bg", 12'h123);
    check("map_addr2", map_addr, 11'd126);
    pix(0, 0, 1, 1, 1);
    rgb_is("rgb_blanked", 12'h000);

    // mirror
    cfg(0, spr(1, 1, 100, 50), 1'b0);
    fstart();
    pix(100, 50, 1, 1, 1);
    check("mir_left", spr_addr[9:0], 10'd22);
    pix(122, 50, 1, 1, 1);
    check("mir_right", spr_addr[9:0], 10'd0);
    rgb_is("mir_rgb", 12'hABC);

    // priority and transparency at (200,100)
    spr_tex[1] = 24'h506070;
    cfg(0, spr(1, 0, 190, 90), 1'b0);
    cfg(1, spr(1, 0, 195, 95), 1'b0);
    fstart();
    pix(200, 100, 1, 1, 1);
    check("prio_sa0", spr_addr[9:0], 10'd240);
    check("prio_sa1", spr_addr[19:10], 10'd120);
    pix(0, 0, 1, 1, 1);
    rgb_is("prio_s0", 12'hABC);
    spr_tex[0] = 24'hFF00FF;
    pix(200, 100, 1, 1, 1);
    pix(0, 0, 1, 1, 1);
    rgb_is("prio_s1", 12'h567);
    spr_tex[1] = 24'hFF00FF;
    solid = 1'b1;
    pix(200, 100, 1, 1, 1);
    pix(0, 0, 1, 1, 1);
    rgb_is("prio_tile", 12'h456);
    solid = 1'b0;
    spr_tex[0] = 24'hA0B0C0;

    // shadow swap: only sprite 0 from here
    cfg(1, 24'h0, 1'b0);
    fstart();
    check("coll_prio", coll_flags, COLL ? 4'b0011 : 4'b0000);
    cfg(0, spr(1, 0, 300, 90), 1'b0);
    pix(200, 100, 1, 1, 1);
    check("shadow_old", spr_addr[9:0], 10'd240);
    pix(0, 0, 1, 1, 1);
    rgb_is("shadow_old_rgb", 12'hABC);
    fstart();
    check("coll_clear", coll_flags, 4'b0000);
    pix(200, 100, 1, 1, 1);
    check("shadow_gone", spr_addr[9:0], 10'd0);
    pix(310, 100, 1, 1, 1);
    check("shadow_new", spr_addr[9:0], 10'd240);
    cfg(0, spr(1, 0, 190, 90), 1'b1);
    pix(310, 100, 1, 1, 1);
    check("coinc_old", spr_addr[9:0], 10'd240);
    fstart();
    pix(310, 100, 1, 1, 1);
    check("coinc_after_x310", spr_addr[9:0], 10'd0);
    pix(200, 100, 1, 1, 1);
    check("coinc_after_x200", spr_addr[9:0], 10'd240);
    rgb_is("coinc_bg", 12'h123);

    // reset mid-line
    pix(195, 95, 1, 0, 0);
    pix(195, 95, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rgb_is("mid_rst_rgb", 12'h000);
    check("mid_rst_sync", {hs, vs}, 2'b11);
    check("mid_rst_addr", {map_addr, pix_addr, spr_addr}, 59'h0);
    pix(195, 95, 1, 1, 1);
    check("rst_disabled", spr_addr[9:0], 10'd0);
    fstart();
    pix(195, 95, 1, 1, 1);
    check("rst_pend_cleared", spr_addr[9:0], 10'd0);
    pix(0, 0, 1, 1, 1);
    rgb_is("rst_resume", 12'h123);

    // collision: sprites 1 and 2 overlap opaquely
    spr_tex[1] = 24'h506070;
    spr_tex[2] = 24'h102030;
    cfg(1, spr(1, 0, 400, 200), 1'b0);
    cfg(2, spr(1, 0, 405, 205), 1'b0);
    fstart();
    pix(410, 210, 1, 1, 1);
    check("coll_sa1", spr_addr[19:10], 10'd240);
    check("coll_sa2", spr_addr[29:20], 10'd120);
    pix(0, 0, 1, 1, 1);
    rgb_is("coll_rgb", 12'h567);
    check("coll_pre", coll_flags, 4'b0000);
    fstart();
    check("coll_set", coll_flags, COLL ? 4'b0110 : 4'b0000);
    pix(0, 0, 1, 1, 1);
    pix(0, 0, 1, 1, 1);
    fstart();
    check("coll_none", coll_flags, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
